instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of the write address.
REQ-002 SHALL have parameter BASE_RST, default 0, write address loaded at reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port op_valid  input  1  an instruction request is presented.
REQ-006 SHALL have port op_ready  output  1  the request is accepted on a cycle where op_valid and op_ready are both 1.
REQ-007 SHALL have port op_kind  input  5  instruction selector.
- 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 AND
- 5 ADDI, 6 SLTI, 7 SLLI, 8 SRLI, 9 SRAI
- 10 LD, 11 LW, 12 LH, 13 LBU
- 14 SD, 15 SW, 16 SH, 17 SB
- 18 BEQ, 19 BNE, 20 BLT, 21 BGE
- 22 LUI, 23 JAL, 24 JALR, 25 NOP, 26 BREAK
- 27-31 illegal
REQ-008 SHALL have ports rd, rs1, rs2  input  5 each  register indices.
REQ-009 SHALL have port imm  input  32  signed immediate; byte offset for branches and jumps.
REQ-010 SHALL have ports base_load  input  1, base_addr  input  ADDR_W; these set the write address.
REQ-011 SHALL have ports wr_en  output  1, wr_addr  output  ADDR_W, wr_data  output  32, wr_ready  input  1; these form the instruction-memory write.
REQ-012 SHALL have ports err  output  1, err_code  output  2 (1 illegal kind, 2 immediate range/alignment), err_clr  input  1.
REQ-013 SHALL have port count  output  16  number of words written, wrapping.

Function
REQ-014 SHALL encode fields using the shared opcode package constants, so that opcode, funct3 and funct7 match the decoder, including F3_SD=3'b111.
REQ-015 SHALL place fields as follows.
- R-type: f7|rs2|rs1|f3|rd|op.
- I-type: imm[11:0]|rs1|f3|rd|op.
- Shifts: f7|imm[4:0]|rs1|f3|rd|op.
- S-type: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
- SB-type: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
- U-type: imm[31:12]|rd|op.
- UJ-type: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
REQ-016 SHALL emit NOP as 0x00000013 and BREAK as 0x00100073, ignoring rd, rs1, rs2 and imm.
REQ-017 SHALL check immediates and flag any violation as error code 2.
- I-type, S-type and JALR: imm must be in [-2048, 2047].
- Shifts: imm must be in [0, 31].
- SB-type: imm must be in [-4096, 4094] and even.
- JAL: imm must be in [-2^20, 2^20-2] and even.
- LUI: imm[11:0] must be 0.
REQ-018 SHALL implement a three-state FSM.
- IDLE: op_ready=1.
- WRITE: wr_en=1, with wr_addr and wr_data held stable.
- ERROR: op_ready=0, wr_en=0.
REQ-019 SHALL move IDLE->WRITE when a valid request is accepted, so the first wr_en occurs exactly 1 cycle after acceptance.
REQ-020 SHALL move IDLE->ERROR when an accepted request is illegal or out of range; that request is consumed, no write occurs, err is set and err_code is loaded.
REQ-021 SHALL, in WRITE with wr_ready=1, complete the write, increment wr_addr by 4 and increment count.
- If op_valid is also 1 in that cycle, op_ready=1 and the next word loads, staying in WRITE for back-to-back throughput of 1 word per cycle.
- Otherwise the FSM returns to IDLE.
REQ-022 SHALL hold wr_en, wr_addr and wr_data unchanged in WRITE while wr_ready=0, with op_ready=0.
REQ-023 SHALL, in ERROR, clear err and return to IDLE the cycle after err_clr=1; err_code is retained until the next error.
REQ-024 SHALL honour base_load only in IDLE or ERROR, loading wr_addr=base_addr; in WRITE it is ignored.
REQ-025 SHALL let wr_addr wrap modulo 2^ADDR_W and count wrap modulo 2^16 without error.
REQ-026 SHALL give base_load priority over an acceptance in the same IDLE cycle, so the accepted word is written at base_addr.

Reset
REQ-027 SHALL, on rst_n low, immediately force state IDLE, wr_en=0, wr_data=0, wr_addr=BASE_RST, count=0, err=0 and err_code=0, independent of clk.
REQ-028 SHALL discard any pending write on reset mid-WRITE, and SHALL drive op_ready=1 from the first edge after rst_n deasserts.

Verification
REQ-029 SHALL cover: ADD rd=3 rs1=1 rs2=2 -> wr_data=0x002081B3 at wr_addr=0 one cycle after acceptance, count=1.
REQ-030 SHALL cover: ADDI rd=5 rs1=0 imm=-1, then BEQ rs1=1 rs2=2 imm=8 back-to-back with wr_ready=1 -> 0xFFF00293 at addr 0, then 0x00208463 at addr 4 on consecutive cycles.
REQ-031 SHALL cover: wr_ready held low 3 cycles during WRITE -> wr_en, wr_addr and wr_data are stable and op_ready=0; the write completes on the 4th cycle.
REQ-032 SHALL cover: ADDI imm=2048 -> no wr_en, err=1, err_code=2, op_ready=0; err_clr -> IDLE; op_kind=30 -> err_code=1.
REQ-033 SHALL cover: base_load with base_addr=0x100, then NOP -> 0x00000013 at 0x100; base_addr=0xFFFFFFFC -> next address wraps to 0.
REQ-034 SHALL cover: rst_n asserted while in WRITE with wr_ready=0 -> wr_en=0 immediately and count=0; after release, wr_addr=BASE_RST.

Source files
------------

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//
// Turns a symbolic instruction request (kind + register indices + immediate)
// into a 32-bit RV-style machine word and writes it to instruction memory at
// an auto-incrementing word address. Illegal kinds and out-of-range or
// misaligned immediates are consumed without a write and latched as an error
// until err_clr.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   op_valid / op_ready   request handshake
//   op_kind               instruction selector (0..26 legal, 27..31 illegal)
//   rd, rs1, rs2, imm     operand fields; imm is a signed byte offset
//   base_load, base_addr  reload the write address (IDLE/ERROR only)
//   wr_en, wr_addr,       instruction-memory write; held stable until
//   wr_data, wr_ready     wr_ready is seen high
//   err, err_code, err_clr sticky error flag, cause (1 illegal, 2 imm), clear
//   count                 words written, wraps modulo 2^16
// ----------------------------------------------------------------------------
module instr_encoder #(
    parameter int unsigned      ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] BASE_RST = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [4:0]        op_kind,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ready,
    output logic              err,
    output logic [1:0]        err_code,
    input  logic              err_clr,
    output logic [15:0]       count
);

    // ------------------------------------------------------------------------
    // Opcode / funct constants shared with the decoder
    // ------------------------------------------------------------------------
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_LD   = 3'b011;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LBU  = 3'b100;
    // The decoder this feeds expects SD under funct3 111, not the usual 011.
    localparam logic [2:0] F3_SD   = 3'b111;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
    localparam logic [31:0] BREAK_WORD = 32'h0010_0073;

    localparam logic [4:0] K_ADD   = 5'd0;
    localparam logic [4:0] K_SUB   = 5'd1;
    localparam logic [4:0] K_SLL   = 5'd2;
    localparam logic [4:0] K_SLT   = 5'd3;
    localparam logic [4:0] K_AND   = 5'd4;
    localparam logic [4:0] K_ADDI  = 5'd5;
    localparam logic [4:0] K_SLTI  = 5'd6;
    localparam logic [4:0] K_SLLI  = 5'd7;
    localparam logic [4:0] K_SRLI  = 5'd8;
    localparam logic [4:0] K_SRAI  = 5'd9;
    localparam logic [4:0] K_LD    = 5'd10;
    localparam logic [4:0] K_LW    = 5'd11;
    localparam logic [4:0] K_LH    = 5'd12;
    localparam logic [4:0] K_LBU   = 5'd13;
    localparam logic [4:0] K_SD    = 5'd14;
    localparam logic [4:0] K_SW    = 5'd15;
    localparam logic [4:0] K_SH    = 5'd16;
    localparam logic [4:0] K_SB    = 5'd17;
    localparam logic [4:0] K_BEQ   = 5'd18;
    localparam logic [4:0] K_BNE   = 5'd19;
    localparam logic [4:0] K_BLT   = 5'd20;
    localparam logic [4:0] K_BGE   = 5'd21;
    localparam logic [4:0] K_LUI   = 5'd22;
    localparam logic [4:0] K_JAL   = 5'd23;
    localparam logic [4:0] K_JALR  = 5'd24;
    localparam logic [4:0] K_NOP   = 5'd25;
    localparam logic [4:0] K_BREAK = 5'd26;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_IMM     = 2'd2;

    typedef enum logic [3:0] {
        FmtR, FmtI, FmtSh, FmtS, FmtB, FmtU, FmtJ, FmtNop, FmtBreak, FmtIll
    } fmt_e;

    typedef enum logic [1:0] {StIdle, StWrite, StError} state_e;

    // ------------------------------------------------------------------------
    // Kind decode: instruction format plus opcode/funct fields
    // ------------------------------------------------------------------------
    fmt_e       fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    always_comb begin
        fmt = FmtIll;
        opc = OPC_OP;
        f3  = F3_ADD;
        f7  = F7_BASE;
        case (op_kind)
            K_ADD:   begin fmt = FmtR;  opc = OPC_OP;  f3 = F3_ADD; end
            K_SUB:   begin fmt = FmtR;  opc = OPC_OP;  f3 = F3_ADD; f7 = F7_ALT; end
            K_SLL:   begin fmt = FmtR;  opc = OPC_OP;  f3 = F3_SLL; end
            K_SLT:   begin fmt = FmtR;  opc = OPC_OP;  f3 = F3_SLT; end
            K_AND:   begin fmt = FmtR;  opc = OPC_OP;  f3 = F3_AND; end
            K_ADDI:  begin fmt = FmtI;  opc = OPC_OP_IMM; f3 = F3_ADD; end
            K_SLTI:  begin fmt = FmtI;  opc = OPC_OP_IMM; f3 = F3_SLT; end
            K_SLLI:  begin fmt = FmtSh; opc = OPC_OP_IMM; f3 = F3_SLL; end
            K_SRLI:  begin fmt = FmtSh; opc = OPC_OP_IMM; f3 = F3_SR;  end
            K_SRAI:  begin fmt = FmtSh; opc = OPC_OP_IMM; f3 = F3_SR;  f7 = F7_ALT; end
            K_LD:    begin fmt = FmtI;  opc = OPC_LOAD;   f3 = F3_LD;  end
            K_LW:    begin fmt = FmtI;  opc = OPC_LOAD;   f3 = F3_LW;  end
            K_LH:    begin fmt = FmtI;  opc = OPC_LOAD;   f3 = F3_LH;  end
            K_LBU:   begin fmt = FmtI;  opc = OPC_LOAD;   f3 = F3_LBU; end
            K_SD:    begin fmt = FmtS;  opc = OPC_STORE;  f3 = F3_SD;  end
            K_SW:    begin fmt = FmtS;  opc = OPC_STORE;  f3 = F3_SW;  end
            K_SH:    begin fmt = FmtS;  opc = OPC_STORE;  f3 = F3_SH;  end
            K_SB:    begin fmt = FmtS;  opc = OPC_STORE;  f3 = F3_SB;  end
            K_BEQ:   begin fmt = FmtB;  opc = OPC_BRANCH; f3 = F3_BEQ; end
            K_BNE:   begin fmt = FmtB;  opc = OPC_BRANCH; f3 = F3_BNE; end
            K_BLT:   begin fmt = FmtB;  opc = OPC_BRANCH; f3 = F3_BLT; end
            K_BGE:   begin fmt = FmtB;  opc = OPC_BRANCH; f3 = F3_BGE; end
            K_LUI:   begin fmt = FmtU;  opc = OPC_LUI; end
            K_JAL:   begin fmt = FmtJ;  opc = OPC_JAL; end
            K_JALR:  begin fmt = FmtI;  opc = OPC_JALR;   f3 = F3_JALR; end
            K_NOP:   fmt = FmtNop;
            K_BREAK: fmt = FmtBreak;
            default: fmt = FmtIll;
        endcase
    end

    // ------------------------------------------------------------------------
    // Immediate range checks
    // ------------------------------------------------------------------------
    logic signed [31:0] imm_s;
    logic               fits_i, fits_sh, fits_b, fits_j, fits_u;

    assign imm_s   = $signed(imm);
    assign fits_i  = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign fits_sh = (imm[31:5] == 27'd0);
    assign fits_b  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
    assign fits_j  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];
    assign fits_u  = (imm[11:0] == 12'd0);

    // ------------------------------------------------------------------------
    // Field packing and error classification
    // ------------------------------------------------------------------------
    logic [31:0] enc_word;
    logic [1:0]  enc_code;

    always_comb begin
        enc_word = '0;
        enc_code = ERR_NONE;
        unique case (fmt)
            FmtR: enc_word = {f7, rs2, rs1, f3, rd, opc};
            FmtI: begin
                enc_word = {imm[11:0], rs1, f3, rd, opc};
                if (!fits_i) enc_code = ERR_IMM;
            end
            FmtSh: begin
                enc_word = {f7, imm[4:0], rs1, f3, rd, opc};
                if (!fits_sh) enc_code = ERR_IMM;
            end
            FmtS: begin
                enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
                if (!fits_i) enc_code = ERR_IMM;
            end
            FmtB: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
                if (!fits_b) enc_code = ERR_IMM;
            end
            FmtU: begin
                enc_word = {imm[31:12], rd, opc};
                if (!fits_u) enc_code = ERR_IMM;
            end
            FmtJ: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                if (!fits_j) enc_code = ERR_IMM;
            end
            FmtNop:   enc_word = NOP_WORD;
            FmtBreak: enc_word = BREAK_WORD;
            default:  enc_code = ERR_ILLEGAL;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [15:0]        count_q, count_d;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;
    logic               accept;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        count_d  = count_q;
        err_d    = err_q;
        code_d   = code_q;
        op_ready = 1'b0;
        wr_en    = 1'b0;
        accept   = 1'b0;

        unique case (state_q)
            StIdle: begin
                op_ready = 1'b1;
                // A base reload in the same cycle as an acceptance wins, so
                // the accepted word lands at base_addr.
                if (base_load) addr_d = base_addr;
                accept = op_valid;
            end
            StWrite: begin
                wr_en    = 1'b1;
                // Only a completing write frees the slot for the next word.
                op_ready = wr_ready;
                if (wr_ready) begin
                    addr_d  = addr_q + ADDR_W'(4);
                    count_d = count_q + 16'd1;
                    state_d = StIdle;
                    accept  = op_valid;
                end
            end
            StError: begin
                if (base_load) addr_d = base_addr;
                if (err_clr) begin
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            if (enc_code != ERR_NONE) begin
                state_d = StError;
                err_d   = 1'b1;
                code_d  = enc_code;
            end else begin
                data_d  = enc_word;
                state_d = StWrite;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= BASE_RST;
            data_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign count    = count_q;
    assign err      = err_q;
    assign err_code = code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder: directed self-checking bench for instr_encoder.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  op_kind;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        base_load;
    logic [31:0] base_addr;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        err;
    logic [1:0]  err_code;
    logic        err_clr;
    logic [15:0] count;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [31:0] exp_addr;
    logic [15:0] exp_count;

    instr_encoder #(
        .ADDR_W   (32),
        .BASE_RST (32'h0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_kind   (op_kind),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .base_load (base_load),
        .base_addr (base_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .err       (err),
        .err_code  (err_code),
        .err_clr   (err_clr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %08h exp %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [4:0] k, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [31:0] im);
        op_kind  = k;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        imm      = im;
        op_valid = 1'b1;
    endtask

    // Single legal write with wr_ready=1; exp_addr/exp_count track the expected state.
    task automatic do_write(input string tag, input logic [4:0] k, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2,
                            input logic [31:0] im, input logic [31:0] exp_word);
        present(k, d, s1, s2, im);
        check({tag, "_rdy"}, 32'(op_ready), 32'd1);
        tick();
        op_valid = 1'b0;
        check({tag, "_wen"}, 32'(wr_en), 32'd1);
        check({tag, "_data"}, wr_data, exp_word);
        check({tag, "_addr"}, wr_addr, exp_addr);
        tick();
        exp_addr  = exp_addr + 32'd4;
        exp_count = exp_count + 16'd1;
        check({tag, "_done"}, 32'(wr_en), 32'd0);
        check({tag, "_cnt"}, 32'(count), 32'(exp_count));
    endtask

    // Rejected request: no write, error latched, then cleared.
    task automatic do_error(input string tag, input logic [4:0] k, input logic [31:0] im,
                            input logic [1:0] exp_code);
        present(k, 5'd1, 5'd2, 5'd3, im);
        tick();
        op_valid = 1'b0;
        check({tag, "_wen"}, 32'(wr_en), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd1);
        check({tag, "_code"}, 32'(err_code), 32'(exp_code));
        check({tag, "_rdy"}, 32'(op_ready), 32'd0);
        check({tag, "_cnt"}, 32'(count), 32'(exp_count));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check({tag, "_clr"}, 32'(err), 32'd0);
        check({tag, "_idle"}, 32'(op_ready), 32'd1);
        check({tag, "_keep"}, 32'(err_code), 32'(exp_code));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_addr  = 32'h0;
        exp_count = 16'd0;
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op_kind   = 5'd0;
        rd        = 5'd0;
        rs1       = 5'd0;
        rs2       = 5'd0;
        imm       = 32'd0;
        base_load = 1'b0;
        base_addr = 32'd0;
        wr_ready  = 1'b1;
        err_clr   = 1'b0;

        // Reset state
        #3;
        check("rst_wen", 32'(wr_en), 32'd0);
        check("rst_addr", wr_addr, 32'h0);
        check("rst_data", wr_data, 32'h0);
        check("rst_cnt", 32'(count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_rdy", 32'(op_ready), 32'd1);

        // ADD x3,x1,x2
        do_write("add", 5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3);

        // ADDI then BEQ back to back, with base reload to 0 on the first accept
        present(5'd5, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
        base_load = 1'b1;
        base_addr = 32'h0;
        tick();
        base_load = 1'b0;
        exp_addr  = 32'h0;
        check("b2b_wen0", 32'(wr_en), 32'd1);
        check("b2b_data0", wr_data, 32'hFFF00293);
        check("b2b_addr0", wr_addr, 32'h0);
        present(5'd18, 5'd0, 5'd1, 5'd2, 32'd8);
        check("b2b_rdy", 32'(op_ready), 32'd1);
        tick();
        op_valid = 1'b0;
        check("b2b_wen1", 32'(wr_en), 32'd1);
        check("b2b_data1", wr_data, 32'h00208463);
        check("b2b_addr1", wr_addr, 32'h4);
        check("b2b_cnt1", 32'(count), 32'd2);
        tick();
        exp_addr  = 32'h8;
        exp_count = 16'd3;
        check("b2b_done", 32'(wr_en), 32'd0);
        check("b2b_cnt2", 32'(count), 32'd3);

        // SW x3,12(x2) with wr_ready low for 3 cycles; base_load ignored in WRITE
        wr_ready = 1'b0;
        present(5'd15, 5'd0, 5'd2, 5'd3, 32'd12);
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall%0d_wen", i), 32'(wr_en), 32'd1);
            check($sformatf("stall%0d_addr", i), wr_addr, 32'h8);
            check($sformatf("stall%0d_data", i), wr_data, 32'h00312623);
            check($sformatf("stall%0d_rdy", i), 32'(op_ready), 32'd0);
            base_load = (i == 1);
            base_addr = 32'h200;
            if (i < 2) tick();
        end
        base_load = 1'b0;
        wr_ready  = 1'b1;
        tick();
        check("stall_done", 32'(wr_en), 32'd0);
        check("stall_addr", wr_addr, 32'hC);
        check("stall_cnt", 32'(count), 32'd4);
        exp_addr  = 32'hC;
        exp_count = 16'd4;

        // Encoding of other formats, including in-range boundaries
        do_write("srai", 5'd9, 5'd1, 5'd2, 5'd0, 32'd3, 32'h40315093);
        do_write("sd", 5'd14, 5'd0, 5'd2, 5'd3, 32'd0, 32'h00317023);
        do_write("jal", 5'd23, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h001000EF);
        do_write("lui", 5'd22, 5'd2, 5'd0, 5'd0, 32'h12345000, 32'h12345137);
        do_write("addi_max", 5'd5, 5'd5, 5'd0, 5'd0, 32'd2047, 32'h7FF00293);

        // Rejections
        do_error("addi_2048", 5'd5, 32'd2048, 2'd2);
        do_error("kind30", 5'd30, 32'd0, 2'd1);
        do_error("beq_odd", 5'd18, 32'd7, 2'd2);
        do_error("slli_32", 5'd7, 32'd32, 2'd2);
        do_error("lui_low", 5'd22, 32'h0000_0123, 2'd2);
        do_error("jal_2p20", 5'd23, 32'h0010_0000, 2'd2);

        // base_load then NOP with junk operands
        base_load = 1'b1;
        base_addr = 32'h100;
        tick();
        base_load = 1'b0;
        check("base_addr", wr_addr, 32'h100);
        exp_addr = 32'h100;
        do_write("nop", 5'd25, 5'd7, 5'd9, 5'd11, 32'h1234_5678, 32'h00000013);

        // Address wrap via BREAK at the top word
        base_load = 1'b1;
        base_addr = 32'hFFFF_FFFC;
        tick();
        base_load = 1'b0;
        exp_addr = 32'hFFFF_FFFC;
        do_write("break", 5'd26, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'h00100073);
        check("wrap_addr", wr_addr, 32'h0);

        // Reset in the middle of a stalled write
        wr_ready = 1'b0;
        present(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        op_valid = 1'b0;
        check("mid_wen", 32'(wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wen", 32'(wr_en), 32'd0);
        check("mid_rst_cnt", 32'(count), 32'd0);
        check("mid_rst_data", wr_data, 32'h0);
        tick();
        rst_n    = 1'b0;
        #2;
        rst_n    = 1'b1;
        wr_ready = 1'b1;
        tick();
        check("post_rst_rdy", 32'(op_ready), 32'd1);
        check("post_rst_addr", wr_addr, 32'h0);
        check("post_rst_wen", 32'(wr_en), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
